// File: rtl/q2_resp_checker_pkg.sv
// Shared types and sizes for the q2 exhaustive response checker.
package q2_resp_checker_pkg;

  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned ERR_W   = 6;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Number of mismatching outputs (0..2) for one sampled vector.
  function automatic logic [1:0] mismatch_count(input logic f, input logic g,
                                                input logic exp_f, input logic exp_g);
    return 2'({1'b0, f ^ exp_f} + {1'b0, g ^ exp_g});
  endfunction

endpackage

// File: rtl/q2_settle_timer.sv
// Loadable down-counter; expire_c is high in the last cycle of the settle window.
module q2_settle_timer
  import q2_resp_checker_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] count,
  output logic             expire_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= count;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Counter parks at zero, so the pulse fires once per load.
  assign expire_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/q2_resp_checker.sv
// Sweeps all 16 q2 input vectors, captures f/g truth tables and compares
// them against expected tables, reporting pass, error count and first failure.
module q2_resp_checker
  import q2_resp_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXP_F         = 16'h0000,
  parameter logic [15:0] EXP_G         = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             f,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      f_table,
  output logic [15:0]      g_table,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_fail_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE_CYCLES);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             load_c;
  logic             expire_c;
  logic [1:0]       m_c;
  logic [ERR_W-1:0] err_next_c;

  assign {a, b, c, d} = idx;

  // Timer reloads on every sweep start and on every non-final sample.
  assign load_c = (((state == ST_IDLE) || (state == ST_DONE)) && start) ||
                  ((state == ST_SAMPLE) && (idx != LAST_IDX));

  assign m_c        = mismatch_count(f, g, EXP_F[idx], EXP_G[idx]);
  assign err_next_c = err_count + ERR_W'(m_c);

  q2_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .count    (SETTLE_V),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      f_table        <= '0;
      g_table        <= '0;
      err_count      <= '0;
      first_fail_idx <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state          <= ST_SETTLE;
            idx            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            f_table        <= '0;
            g_table        <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
          end
        end
        ST_SETTLE: begin
          if (expire_c) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          f_table[idx] <= f;
          g_table[idx] <= g;
          err_count    <= err_next_c;
          // A zero running count means no earlier vector has failed.
          if ((m_c != 2'd0) && (err_count == '0)) first_fail_idx <= idx;
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next_c == '0);
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q2_resp_checker.sv
// Bench for q2_resp_checker: behavioural q2 model with selectable faults,
// table of sweeps scored through a queue, plus timing/reset/restart sequences.
module tb_q2_resp_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  int   mode = 0;

  logic        a1, b1, c1, d1, f1, g1, busy1, done1, pass1;
  logic [15:0] ft1, gt1;
  logic [5:0]  ec1;
  logic [3:0]  ffi1;
  logic        a2, b2, c2, d2, f2, g2, busy2, done2, pass2;
  logic [15:0] ft2, gt2;
  logic [5:0]  ec2;
  logic [3:0]  ffi2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // q2 model: 0 golden (f=a&b, g=c|d), 1 f stuck-at-0, 2 f inverted and g stuck-at-1.
  function automatic logic model_f(input logic [3:0] v, input int md);
    case (md)
      1:       return 1'b0;
      2:       return ~(v[3] & v[2]);
      default: return v[3] & v[2];
    endcase
  endfunction

  function automatic logic model_g(input logic [3:0] v, input int md);
    case (md)
      2:       return 1'b1;
      default: return v[1] | v[0];
    endcase
  endfunction

  assign f1 = model_f({a1, b1, c1, d1}, mode);
  assign g1 = model_g({a1, b1, c1, d1}, mode);
  assign f2 = model_f({a2, b2, c2, d2}, 0);
  assign g2 = model_g({a2, b2, c2, d2}, 0);

  q2_resp_checker #(.SETTLE_CYCLES(2), .EXP_F(16'hF000), .EXP_G(16'hEEEE)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1), .f(f1), .g(g1),
    .busy(busy1), .done(done1), .pass(pass1),
    .f_table(ft1), .g_table(gt1), .err_count(ec1), .first_fail_idx(ffi1)
  );

  q2_resp_checker #(.SETTLE_CYCLES(1), .EXP_F(16'hF000), .EXP_G(16'hEEEE)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .a(a2), .b(b2), .c(c2), .d(d2), .f(f2), .g(g2),
    .busy(busy2), .done(done2), .pass(pass2),
    .f_table(ft2), .g_table(gt2), .err_count(ec2), .first_fail_idx(ffi2)
  );

  typedef struct {
    int          md;
    logic        exp_pass;
    logic [5:0]  exp_err;
    logic [3:0]  exp_ffi;
    logic [15:0] exp_f;
    logic [15:0] exp_g;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pop the expected result for a finished dut1 sweep and compare it.
  task automatic score1();
    vec_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("pass", {31'd0, pass1}, {31'd0, e.exp_pass});
      chk("err_count", {26'd0, ec1}, {26'd0, e.exp_err});
      chk("first_fail_idx", {28'd0, ffi1}, {28'd0, e.exp_ffi});
      chk("f_table", {16'd0, ft1}, {16'd0, e.exp_f});
      chk("g_table", {16'd0, gt1}, {16'd0, e.exp_g});
      chk("abcd_at_done", {28'd0, a1, b1, c1, d1}, 32'hF);
    end
  endtask

  // Pulse start on dut1, check the cleared state, wait bounded for done and score.
  task automatic run1(input vec_t e);
    int cyc;
    sb.push_back(e);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("done_cleared", {31'd0, done1}, 32'd0);
    chk("err_cleared", {26'd0, ec1}, 32'd0);
    chk("busy_set", {31'd0, busy1}, 32'd1);
    cyc = 0;
    while (!done1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency1", cyc, 32'd48);
    score1();
  endtask

  initial begin
    int   cyc;
    int   run;
    int   bad;
    int   changes;
    logic [3:0] prev;
    logic [3:0] cur;

    tbl[0] = '{0, 1'b1, 6'd0,  4'd0,  16'hF000, 16'hEEEE};
    tbl[1] = '{1, 1'b0, 6'd4,  4'd12, 16'h0000, 16'hEEEE};
    tbl[2] = '{2, 1'b0, 6'd20, 4'd0,  16'h0FFF, 16'hFFFF};

    // Reset state, before any clock edge.
    #1;
    chk("rst_abcd", {28'd0, a1, b1, c1, d1}, 32'd0);
    chk("rst_flags", {29'd0, busy1, done1, pass1}, 32'd0);
    chk("rst_tables", {ft1, gt1}, 32'd0);
    chk("rst_err", {22'd0, ec1, ffi1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Busy-start on the 1-cycle-settle instance: restart pulse must be ignored.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0; run = 1; bad = 0; changes = 0;
    prev = {a2, b2, c2, d2};
    while (!done2 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        chk("busy2_mid", {31'd0, busy2}, 32'd1);
        start2 = 1'b1;
      end
      if (cyc == 11) start2 = 1'b0;
      cur = {a2, b2, c2, d2};
      if (cur == prev) run++;
      else begin
        if (run != 2 || cur != prev + 4'd1) bad++;
        changes++;
        run = 1;
        prev = cur;
      end
    end
    chk("latency2", cyc, 32'd32);
    chk("hold2_bad_runs", bad, 32'd0);
    chk("hold2_changes", changes, 32'd15);
    chk("pass2", {31'd0, pass2}, 32'd1);
    chk("err2", {26'd0, ec2}, 32'd0);
    chk("tables2", {ft2, gt2}, 32'hF000EEEE);

    // Table-driven sweeps on dut1: golden, f stuck-at-0, double fault.
    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].md;
      run1(tbl[i]);
      @(negedge clk);
      chk("done_held", {31'd0, done1}, 32'd1);
    end

    // Restart from DONE after the failing sweep with a repaired model.
    mode = 0;
    run1(tbl[0]);

    // Reset in the middle of a sweep, at idx 7.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while ({a1, b1, c1, d1} != 4'd7 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_idx7", {28'd0, a1, b1, c1, d1}, 32'd7);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_abcd", {28'd0, a1, b1, c1, d1}, 32'd0);
    chk("midrst_flags", {29'd0, busy1, done1, pass1}, 32'd0);
    chk("midrst_tables", {ft1, gt1}, 32'd0);
    chk("midrst_err", {22'd0, ec1, ffi1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", {30'd0, busy1, done1}, 32'd0);
    run1(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/q2_resp_checker.md
Name: q2_resp_checker

Overview:
- Self-checking response analyser for the 4-input, 2-output q2 combinational block.
- Sweeps all 16 input combinations on a,b,c,d, waits a settle interval per vector, then samples f and g.
- Builds captured truth tables and compares them against expected tables.
- Reports pass/fail, mismatch count and first failing vector; gives on-chip exhaustive check of the q2 logic without a simulator bench.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15.
- EXP_F, 16'h0000, expected f truth table; bit i = f for vector i.
- EXP_G, 16'h0000, expected g truth table; bit i = g for vector i.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin sweep; sampled in IDLE or DONE only
- a  output  1  stimulus, vector index bit 3 (MSB)
- b  output  1  stimulus, index bit 2
- c  output  1  stimulus, index bit 1
- d  output  1  stimulus, index bit 0
- f  input  1  DUT response f
- g  input  1  DUT response g
- busy  output  1  high during SETTLE/SAMPLE
- done  output  1  high in DONE, held until next start or reset
- pass  output  1  valid when done; 1 iff zero mismatches
- f_table  output  16  captured f per vector
- g_table  output  16  captured g per vector
- err_count  output  6  number of mismatching bits, 0..32
- first_fail_idx  output  4  index of first vector with any mismatch; valid when done and !pass

Behaviour:
- One clock: clk. Reset: asynchronous, active-low rst_n.
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset, asynchronous and immediate:
  - state=IDLE; idx=0; {a,b,c,d}=0.
  - busy, done and pass = 0.
  - f_table, g_table, err_count and first_fail_idx = 0.
  - Reset mid-sweep aborts the sweep with no residual state.
- {a,b,c,d} = idx at all times, registered. Vector order 0000..1111, a is MSB.
- IDLE/DONE + start=1 at an edge:
  - idx=0; clear tables, err_count and first_fail_idx.
  - done=0, pass=0.
  - settle counter = SETTLE_CYCLES; go to SETTLE.
- SETTLE: decrement counter each cycle; stay exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE, one cycle, at the edge:
  - f_table[idx]<=f; g_table[idx]<=g.
  - m = (f!=EXP_F[idx]) + (g!=EXP_G[idx]); err_count += m.
  - If m!=0 and this is the first failure of the sweep, first_fail_idx<=idx.
  - If idx==15: go to DONE and set done=1, pass=(final err_count==0), including the current m.
  - Otherwise: idx+1, reload the counter, go to SETTLE.
- Latency: done rises 16*(SETTLE_CYCLES+1) cycles after the edge that samples start. SETTLE_CYCLES=2 gives 48 cycles.
- start while busy: ignored, with no effect on the sweep.
- start held high across DONE: immediately restarts; done is high for exactly one cycle.
- DONE with start low: all results held stable indefinitely; {a,b,c,d} stays at 1111.
- err_count never wraps; maximum is 32, which fits in 6 bits.
- f and g are sampled only in SAMPLE; glitches during SETTLE are ignored.

Decomposition:
- Shared header q2_defs.vh:
  - state encoding localparams (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - NUM_VEC=16; IDX_W=4; ERR_W=6.
- One natural sub-module: q2_settle_timer.
  - Inputs: load, count value. Output: expire pulse.
  - Isolates the down-counter from the sweep FSM.

Test Plan:
- Golden pass:
  - DUT model f=a&b, g=c|d; EXP_F=16'hF000, EXP_G=16'hEEEE, SETTLE_CYCLES=2; pulse start.
  - Required: done at +48 cycles, pass=1, err_count=0, f_table=16'hF000, g_table=16'hEEEE.
- Fault injection:
  - Same setup, f stuck-at-0.
  - Required: pass=0, err_count=4, first_fail_idx=12, f_table=16'h0000, g_table=16'hEEEE.
- Double fault:
  - f inverted and g stuck-at-1.
  - Required: err_count=16+4=20, first_fail_idx=0, pass=0.
- Busy-start and timing:
  - SETTLE_CYCLES=1; pulse start again at +10 cycles.
  - Required: sweep undisturbed, done at +32 cycles; each {a,b,c,d} value held exactly 2 cycles.
- Reset mid-sweep:
  - Assert rst_n=0 at idx=7.
  - Required: outputs 0 immediately, without waiting for a clock edge; state IDLE; a fresh start then completes normally with pass=1.
- Restart from DONE:
  - After a failing sweep, fix the DUT and start again.
  - Required: done drops the cycle after start, counters clear, the new sweep gives pass=1 and err_count=0.
